// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event counters plus a free-running cycle counter,
// with freeze-on-halt, snapshot shadows and a latency-1 read port.
module perf_counter_bank #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ev,
  input  logic              count_en,
  input  logic              halt,
  input  logic              clear,
  input  logic              snap,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_shadow,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic [NUM_CH:0]   ovf,
  output logic              frozen
);

  localparam int NCNT = NUM_CH + 1;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [SEL_W-1:0] CYC_SEL = SEL_W'(NUM_CH);

  typedef enum logic {RUN, FROZEN} state_t;

  state_t state;
  state_t stateNext;

  logic [CNT_W-1:0] cnt    [NCNT];
  logic [CNT_W-1:0] shadow [NCNT];
  logic [NCNT-1:0]  inc;
  logic [CNT_W-1:0] rdMux;
  logic             rdOor;

  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:    if (halt) stateNext = FROZEN;
      FROZEN: if (clear && !halt) stateNext = RUN;
    endcase
  end

  // Index NUM_CH is the cycle counter; it ignores stalls.
  always_comb begin
    inc = '0;
    if (state == RUN) begin
      inc = {1'b1, ev & {NUM_CH{count_en}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      ovf   <= '0;
      for (int k = 0; k < NCNT; k++) begin
        cnt[k]    <= '0;
        shadow[k] <= '0;
      end
    end else begin
      state <= stateNext;
      for (int k = 0; k < NCNT; k++) begin
        if (snap) shadow[k] <= cnt[k];
        if (clear) begin
          cnt[k] <= '0;
          ovf[k] <= 1'b0;
        end else if (inc[k]) begin
          if (cnt[k] == ALL_ONES) ovf[k] <= 1'b1;
          if (cnt[k] != ALL_ONES || SAT_MODE == 0)
            cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rdMux = '0;
    rdOor = (rd_sel > CYC_SEL);
    for (int k = 0; k < NCNT; k++) begin
      if (rd_sel == SEL_W'(k))
        rdMux = rd_shadow ? shadow[k] : cnt[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= (rd_req && !rdOor) ? rdMux : '0;
      rd_err   <= rd_req && rdOor;
    end
  end

  assign frozen = (state == FROZEN);

endmodule
